// File: rtl/pds_pkg.sv
// pds_pkg: shared types, default parameters and field-extraction helper for
// the power-distribution scheduler (pds_sched) and its priority selector.
package pds_pkg;

    typedef enum logic [1:0] {
        EVAL   = 2'd0,
        INRUSH = 2'd1,
        SHED   = 2'd2
    } pds_state_e;

    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_PRIO_W     = 2;
    localparam int DEF_PWR_W      = 8;
    localparam int DEF_CLS_W      = 4;
    localparam int DEF_INRUSH_CYC = 4;

    // Packed per-port fields are pulled out of a vector of at most this width,
    // each field being at most FIELD_MAX_W bits wide.
    localparam int FIELD_VEC_W = 64;
    localparam int FIELD_MAX_W = 8;

    // Selector modes: MAX picks highest priority (lowest index wins ties),
    // MIN picks lowest priority (highest index wins ties).
    localparam logic SEL_MAX = 1'b0;
    localparam logic SEL_MIN = 1'b1;

    // Return field idx of width w from a packed vector, zero-extended.
    function automatic logic [FIELD_MAX_W-1:0] get_field(
        input logic [FIELD_VEC_W-1:0] vec,
        input int unsigned            idx,
        input int unsigned            w
    );
        logic [FIELD_VEC_W-1:0] sh;
        logic [FIELD_MAX_W-1:0] mask;
        sh   = vec >> (idx * w);
        mask = (FIELD_MAX_W'(1) << w) - FIELD_MAX_W'(1);
        return sh[FIELD_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/pds_prio_sel.sv
// pds_prio_sel: combinational one-hot selector over a candidate mask.
// mode SEL_MAX -> highest priority, lowest index on ties.
// mode SEL_MIN -> lowest priority, highest index on ties.
module pds_prio_sel
    import pds_pkg::*;
#(
    parameter int N  = DEF_NUM_PORTS,
    parameter int PW = DEF_PRIO_W
) (
    input  logic [N-1:0]    cand,
    input  logic [N*PW-1:0] prio,
    input  logic            mode,
    output logic [N-1:0]    gnt,
    output logic            vld
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] p_s;
    logic [PW-1:0] best_p_s;
    logic [IW-1:0] best_i_s;
    logic          take_s;

    // Linear scan: strict '>' keeps the lowest index in MAX mode, '<=' moves
    // to the highest index in MIN mode.
    always_comb begin
        vld      = 1'b0;
        best_p_s = '0;
        best_i_s = '0;
        p_s      = '0;
        take_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            p_s = PW'(get_field(FIELD_VEC_W'(prio), i, PW));
            if (!cand[i]) begin
                take_s = 1'b0;
            end else if (!vld) begin
                take_s = 1'b1;
            end else if (mode == SEL_MAX) begin
                take_s = (p_s > best_p_s);
            end else begin
                take_s = (p_s <= best_p_s);
            end
            best_p_s = take_s ? p_s : best_p_s;
            best_i_s = take_s ? IW'(i) : best_i_s;
            vld      = vld | take_s;
        end
        gnt = vld ? (N'(1) << best_i_s) : '0;
    end

endmodule

// File: rtl/pds_sched.sv
// pds_sched: power-distribution scheduler. Grants power to detected ports in
// priority order against a programmable budget, staggers turn-ons by an
// inrush window and sheds lowest-priority ports when over budget.
// Optional feature macro: PDS_SHED_EN (SHED state and over-budget aborts).
module pds_sched
    import pds_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int PRIO_W     = DEF_PRIO_W,
    parameter int PWR_W      = DEF_PWR_W,
    parameter int CLS_W      = DEF_CLS_W,
    parameter int INRUSH_CYC = DEF_INRUSH_CYC
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PORTS-1:0]              det,
    input  logic [NUM_PORTS-1:0]              off,
    input  logic [NUM_PORTS*PRIO_W-1:0]       prio,
    input  logic [NUM_PORTS*CLS_W-1:0]        port_pwr,
    input  logic [PWR_W-1:0]                  pwr_bdj,
    input  logic                              ports_off,
    output logic [NUM_PORTS-1:0]              on,
    output logic [PWR_W+$clog2(NUM_PORTS):0]  used_pwr,
    output logic                              inrush
);

    localparam int UW    = PWR_W + $clog2(NUM_PORTS) + 1;
    localparam int CNT_W = (INRUSH_CYC > 1) ? $clog2(INRUSH_CYC) : 1;

    pds_state_e           state_r, state_nxt_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
    logic [NUM_PORTS-1:0] on_r, on_nxt_s;
    logic [UW-1:0]        used_r, used_nxt_s;
    logic                 inrush_r;

    logic [CLS_W-1:0]     cost_s [NUM_PORTS];
    logic [NUM_PORTS-1:0] drop_s, kept_s, elig_s, fit_s;
    logic [UW-1:0]        used_kept_s;
    logic [UW-1:0]        bdj_ext_s;
    logic                 over_s;
    logic [NUM_PORTS-1:0] gnt_s;
    logic                 gnt_vld_s;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cost
        assign cost_s[g] = CLS_W'(get_field(FIELD_VEC_W'(port_pwr), g, CLS_W));
    end

    assign drop_s    = on_r & (~det | off | {NUM_PORTS{ports_off}});
    assign kept_s    = on_r & ~drop_s;
    assign elig_s    = det & ~off & ~{NUM_PORTS{ports_off}} & ~on_r;
    assign bdj_ext_s = UW'(pwr_bdj);
    assign over_s    = (used_kept_s > bdj_ext_s);

    // Power of ports that survive this edge's drops, and which idle ports fit.
    always_comb begin
        used_kept_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            used_kept_s = used_kept_s + (kept_s[i] ? UW'(cost_s[i]) : '0);
        end
        fit_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            fit_s[i] = elig_s[i] & ((used_kept_s + UW'(cost_s[i])) <= bdj_ext_s);
        end
    end

    pds_prio_sel #(.N(NUM_PORTS), .PW(PRIO_W)) u_grant_sel (
        .cand (fit_s),
        .prio (prio),
        .mode (SEL_MAX),
        .gnt  (gnt_s),
        .vld  (gnt_vld_s)
    );

`ifdef PDS_SHED_EN
    logic [NUM_PORTS-1:0] shed_gnt_s;
    logic                 shed_vld_s;

    pds_prio_sel #(.N(NUM_PORTS), .PW(PRIO_W)) u_shed_sel (
        .cand (kept_s),
        .prio (prio),
        .mode (SEL_MIN),
        .gnt  (shed_gnt_s),
        .vld  (shed_vld_s)
    );
`endif

    // FSM next state and next on-vector; drops are already folded into kept_s.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        on_nxt_s    = kept_s;
        case (state_r)
            EVAL: begin
                if (over_s) begin
`ifdef PDS_SHED_EN
                    state_nxt_s = SHED;
`else
                    state_nxt_s = EVAL;
`endif
                end else if (gnt_vld_s) begin
                    on_nxt_s    = kept_s | gnt_s;
                    cnt_nxt_s   = CNT_W'(INRUSH_CYC - 1);
                    state_nxt_s = INRUSH;
                end else begin
                    state_nxt_s = EVAL;
                end
            end
            INRUSH: begin
`ifdef PDS_SHED_EN
                if (over_s) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = SHED;
                end else
`endif
                if (cnt_r == '0) begin
                    state_nxt_s = EVAL;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
`ifdef PDS_SHED_EN
            SHED: begin
                on_nxt_s    = shed_vld_s ? (kept_s & ~shed_gnt_s) : kept_s;
                state_nxt_s = EVAL;
            end
`endif
            default: begin
                state_nxt_s = EVAL;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Allocated power for the next on-vector using the current port costs.
    always_comb begin
        used_nxt_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            used_nxt_s = used_nxt_s + (on_nxt_s[i] ? UW'(cost_s[i]) : '0);
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= EVAL;
            cnt_r    <= '0;
            on_r     <= '0;
            used_r   <= '0;
            inrush_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            on_r     <= on_nxt_s;
            used_r   <= used_nxt_s;
            inrush_r <= (state_nxt_s == INRUSH);
        end
    end

    assign on       = on_r;
    assign used_pwr = used_r;
    assign inrush   = inrush_r;

endmodule

// File: tb/tb_pds_sched.sv
// tb_pds_sched: directed bench for pds_sched (4 ports, PRIO_W=2, CLS_W=4,
// INRUSH_CYC=4). Honours PDS_SHED_EN the same way as the design.
module tb_pds_sched;

    localparam int NP  = 4;
    localparam int INR = 4;
`ifdef PDS_SHED_EN
    localparam bit SHED_ON = 1'b1;
`else
    localparam bit SHED_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  det;
    logic [3:0]  off;
    logic [7:0]  prio;
    logic [15:0] port_pwr;
    logic [7:0]  pwr_bdj;
    logic        ports_off;
    logic [3:0]  on;
    logic [10:0] used_pwr;
    logic        inrush;

    int checks = 0;
    int errors = 0;

    pds_sched #(
        .NUM_PORTS(4), .PRIO_W(2), .PWR_W(8), .CLS_W(4), .INRUSH_CYC(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .det       (det),
        .off       (off),
        .prio      (prio),
        .port_pwr  (port_pwr),
        .pwr_bdj   (pwr_bdj),
        .ports_off (ports_off),
        .on        (on),
        .used_pwr  (used_pwr),
        .inrush    (inrush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model view: which ports are powered, how many cycles of the inrush
    // window remain, whether a shed is owed, and the power they draw.
    typedef struct packed {
        logic [3:0]  on;
        logic [7:0]  wait_c;
        logic        shed;
        logic [10:0] used;
    } mstate_t;

    mstate_t m_s;

    function automatic int cost(int i);
        return int'(port_pwr[i*4 +: 4]);
    endfunction

    function automatic int pr(int i);
        return int'(prio[i*2 +: 2]);
    endfunction

    function automatic mstate_t model_next(mstate_t s);
        mstate_t    n;
        logic [3:0] kept;
        int         ukept;
        int         best;
        int         usum;
        bit         over;
        n     = s;
        kept  = 4'b0000;
        ukept = 0;
        for (int i = 0; i < NP; i++) begin
            if (s.on[i] && det[i] && !off[i] && !ports_off) begin
                kept[i] = 1'b1;
                ukept   = ukept + cost(i);
            end
        end
        n.on = kept;
        over = (ukept > int'(pwr_bdj));
        if (s.shed) begin
            best = -1;
            for (int i = 0; i < NP; i++)
                if (kept[i] && (best < 0 || pr(i) <= pr(best))) best = i;
            if (best >= 0) n.on[best] = 1'b0;
            n.shed = 1'b0;
        end else if (s.wait_c != 8'd0) begin
            if (SHED_ON && over) begin
                n.shed   = 1'b1;
                n.wait_c = 8'd0;
            end else begin
                n.wait_c = s.wait_c - 8'd1;
            end
        end else if (over) begin
            n.shed = SHED_ON;
        end else begin
            best = -1;
            for (int i = 0; i < NP; i++)
                if (det[i] && !off[i] && !ports_off && !s.on[i] &&
                    (ukept + cost(i) <= int'(pwr_bdj)) &&
                    (best < 0 || pr(i) > pr(best))) best = i;
            if (best >= 0) begin
                n.on[best] = 1'b1;
                n.wait_c   = 8'(INR);
            end
        end
        usum = 0;
        for (int i = 0; i < NP; i++) if (n.on[i]) usum = usum + cost(i);
        n.used = 11'(usum);
        return n;
    endfunction

    // Reference model advance on every clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_s <= '0;
        else        m_s <= model_next(m_s);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("model_on",     32'(on),       32'(m_s.on));
        chk("model_used",   32'(used_pwr), 32'(m_s.used));
        chk("model_inrush", 32'(inrush),   32'(m_s.wait_c != 8'd0));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cmp_model();
        end
    endtask

    task automatic lit(input string nm, input logic [3:0] e_on, input int e_used, input logic e_inr);
        chk({nm, "_on"},     32'(on),       32'(e_on));
        chk({nm, "_used"},   32'(used_pwr), 32'(e_used));
        chk({nm, "_inrush"}, 32'(inrush),   32'(e_inr));
    endtask

    initial begin
        rst_n = 1'b0; det = 4'h0; off = 4'h0; prio = 8'h00;
        port_pwr = 16'h0000; pwr_bdj = 8'd0; ports_off = 1'b0;
        step(3);
        lit("reset", 4'b0000, 0, 1'b0);
        rst_n = 1'b1;
        step(2);

        // Stagger: all prio 0, cost 10, budget 100.
        det = 4'b1111; port_pwr = 16'hAAAA; pwr_bdj = 8'd100;
        step(1);  lit("stag_t0",  4'b0001, 10, 1'b1);
        step(3);  lit("stag_t3",  4'b0001, 10, 1'b1);
        step(1);  lit("stag_t4",  4'b0001, 10, 1'b0);
        step(1);  lit("stag_t5",  4'b0011, 20, 1'b1);
        step(5);  lit("stag_t10", 4'b0111, 30, 1'b1);
        step(5);  lit("stag_t15", 4'b1111, 40, 1'b1);

        // Global off: everything drops next edge, nothing turns on meanwhile.
        ports_off = 1'b1;
        step(1);  lit("goff", 4'b0000, 0, 1'b1);
        step(6);  lit("goff_hold", 4'b0000, 0, 1'b0);

        // Priority and fit: port 3 prio 3, budget 15.
        ports_off = 1'b0; prio = 8'hC0; pwr_bdj = 8'd15;
        step(1);  lit("pfit_t0", 4'b1000, 10, 1'b1);
        step(20); lit("pfit_end", 4'b1000, 10, 1'b0);

        // Shed setup: prio {3,2,1,0}, exact-fit budget 40.
        ports_off = 1'b1;
        step(2);
        ports_off = 1'b0; prio = 8'hE4; pwr_bdj = 8'd40;
        step(25); lit("shed_pre", 4'b1111, 40, 1'b0);
        pwr_bdj = 8'd25;
        if (SHED_ON) begin
            step(2);  lit("shed_1", 4'b1110, 30, 1'b0);
            step(2);  lit("shed_2", 4'b1100, 20, 1'b0);
            step(10); lit("shed_end", 4'b1100, 20, 1'b0);
        end else begin
            step(2);  lit("noshed_1", 4'b1111, 40, 1'b0);
            step(10); lit("noshed_end", 4'b1111, 40, 1'b0);
        end

        // Zero-cost port turns on with zero budget.
        ports_off = 1'b1;
        step(2);
        ports_off = 1'b0; det = 4'b0010; port_pwr = 16'h0000; pwr_bdj = 8'd0; prio = 8'h00;
        step(1);  lit("zcost", 4'b0010, 0, 1'b1);

        // Drop during INRUSH.
        ports_off = 1'b1;
        step(6);
        ports_off = 1'b0; det = 4'b0100; port_pwr = 16'hAAAA; pwr_bdj = 8'd100;
        step(1);  lit("drop_on", 4'b0100, 10, 1'b1);
        det = 4'b0000;
        step(1);  lit("drop_off", 4'b0000, 0, 1'b1);
        step(2);  lit("drop_inr", 4'b0000, 0, 1'b1);
        step(1);  lit("drop_done", 4'b0000, 0, 1'b0);

        // Cost change on a powered port shows up one edge later.
        det = 4'b0001;
        step(1);  lit("cchg_on", 4'b0001, 10, 1'b1);
        port_pwr = 16'hAAA5;
        step(1);  lit("cchg_new", 4'b0001, 5, 1'b1);

        // Asynchronous reset in the middle of INRUSH.
        det = 4'b1111;
        step(2);
        #2 rst_n = 1'b0;
        #1 lit("async_rst", 4'b0000, 0, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
